// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants, types and width helper for the shared multiplier
package mul_pkg;

    // Product width that holds the full signed product, including (-2^(W-1))^2
    function automatic int pw(input int w);
        return 2 * w;
    endfunction

    localparam int W       = 4;
    localparam int PW      = pw(W);
    localparam int NUM_REQ = 4;
    localparam int IDW     = $clog2(NUM_REQ);

    typedef logic signed [W-1:0]  operand_t;
    typedef logic signed [PW-1:0] product_t;

endpackage

// File: rtl/mul_share_arb_if.sv
// rtl/mul_share_arb_if.sv - request and response bundle between issue units and the shared multiplier
interface mul_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 4,
    parameter int IDW     = 2,
    parameter int PW      = 8
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic signed [PW-1:0] rsp_p;
    logic [IDW-1:0]       rsp_id;

    // Issue units and the result consumer
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_id
    );

    // The arbiter in front of the shared multiplier
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_id
    );
endinterface

// File: rtl/mul_core_reg.sv
// rtl/mul_core_reg.sv - registered signed W x W multiplier, one cycle latency, enable gated
module mul_core_reg
    import mul_pkg::*;
#(
    parameter int W  = mul_pkg::W,
    parameter int PW = pw(W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic signed [W-1:0]  a_i,
    input  logic signed [W-1:0]  b_i,
    output logic signed [PW-1:0] p_o
);

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] p_d;
    logic signed [PW-1:0] p_q;

    // Sign-extend both operands so the full-width product needs no truncation
    always_comb begin
        a_ext = {{(PW-W){a_i[W-1]}}, a_i};
        b_ext = {{(PW-W){b_i[W-1]}}, b_i};
        p_d   = a_ext * b_ext;
    end

    // Product register; holds while the pipeline is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else if (en) begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin sharing of one registered multiplier among several requesters
module mul_share_arb
    import mul_pkg::*;
#(
    parameter int NUM_REQ = mul_pkg::NUM_REQ,
    parameter int W       = mul_pkg::W,
    parameter int IDW     = $clog2(NUM_REQ),
    parameter int PW      = pw(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_share_arb_if.slave   bus,
    output logic             busy
);

    logic signed [W-1:0] a_arr [NUM_REQ];
    logic signed [W-1:0] b_arr [NUM_REQ];

    logic                stall;
    logic                adv;
    logic [IDW-1:0]      idx;
    logic [IDW-1:0]      gnt_id;
    logic                gnt_any;
    logic                accept;
    logic [NUM_REQ-1:0]  req_ready;

    logic [IDW-1:0]      rr_ptr_q,    rr_ptr_d;
    logic                s1_vld_q,    s1_vld_d;
    logic signed [W-1:0] s1_a_q,      s1_a_d;
    logic signed [W-1:0] s1_b_q,      s1_b_d;
    logic [IDW-1:0]      s1_id_q,     s1_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]      rsp_id_q,    rsp_id_d;
    logic signed [PW-1:0] prod;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = bus.req_a[gi*W +: W];
        assign b_arr[gi] = bus.req_b[gi*W +: W];
    end

    // The whole pipeline moves together unless a finished product is waiting on the consumer
    always_comb begin
        stall = rsp_valid_q & ~bus.rsp_ready;
        adv   = ~stall;
    end

    // Round-robin scan from rr_ptr upward with wrap; first valid requester wins
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!gnt_any && bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    // One-hot ready; depends on rsp_ready only through adv, never on a requester's own ready
    always_comb begin
        req_ready = '0;
        if (adv && gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
        accept = adv & gnt_any;
    end

    assign bus.req_ready = req_ready;

    // Next state for pointer, operand stage and response stage
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        s1_vld_d    = s1_vld_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        if (adv) begin
            s1_vld_d    = accept;
            rsp_valid_d = s1_vld_q;
            if (s1_vld_q) begin
                rsp_id_d = s1_id_q;
            end
            if (accept) begin
                s1_a_d   = a_arr[gnt_id];
                s1_b_d   = b_arr[gnt_id];
                s1_id_d  = gnt_id;
                rr_ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    // Pipeline and pointer registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_vld_q    <= s1_vld_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // The single shared multiplier; its product register is the response data stage
    mul_core_reg #(
        .W  (W),
        .PW (PW)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .p_o   (prod)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_p     = prod;
    assign busy          = s1_vld_q | rsp_valid_q;

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one registered signed multiplier (W x W, 1-cycle latency, `en`-gated) among NUM_REQ requesters.
- Each requester uses a valid/ready request handshake. Results leave on one tagged valid/ready response channel.
- Arbitration is round-robin. A two-stage pipeline (operand register, product register) sits in front of the consumer, with full backpressure.
- Sits between the accelerator's issue units and the shared multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- W, 4, operand width, signed two's complement
- IDW, 2, requester-ID width, equal to clog2(NUM_REQ)
- PW, 8, product width; fixed at 2*W so that (-2^(W-1))^2 is representable (-8*-8 = +64)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*W  packed signed operand A; slot i = bits [i*W +: W]
- req_b  in  NUM_REQ*W  packed signed operand B
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high per cycle
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_p  out  PW  signed product A*B
- rsp_id  out  IDW  index of the requester that issued the operation
- busy  out  1  high when either pipeline stage holds data

Behaviour:
- Reset (async, rst_n low):
  - s1_vld = 0, rsp_valid = 0, rsp_p = 0, rsp_id = 0.
  - Round-robin pointer rr_ptr = 0; busy = 0; req_ready = 0.
  - In-flight operations are discarded, not completed.
- Stages:
  - S1 holds {a, b, id, s1_vld}. The multiplier computes from S1.
  - S2 is the product register, driving {rsp_p, rsp_id, rsp_valid}.
- Stall and advance:
  - stall = rsp_valid & ~rsp_ready.
  - adv = ~stall. adv is the multiplier `en` and the load enable for S1 and S2.
- Arbitration:
  - Combinational. Scan req_valid starting at rr_ptr, ascending with wrap; the first set bit is grant g.
  - req_ready[g] = adv & |req_valid. All other bits are 0.
  - req_ready never depends on rsp_ready through any path other than adv. No ready->valid loop on the request side.
- Accept at rising edge k (req_valid[g] & req_ready[g]):
  - S1 <= {req_a[g], req_b[g], g, 1}.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - If there is no accept and adv is high: s1_vld <= 0; rr_ptr is unchanged.
- Latency:
  - Accepted at edge k -> rsp_valid high after edge k+1, with an empty stall path.
  - Throughput is 1 op/cycle while rsp_ready stays high.
- S2 load on adv:
  - rsp_valid <= s1_vld; rsp_p <= product; rsp_id <= S1.id.
  - When s1_vld = 0, rsp_p and rsp_id hold their previous value (don't-care for checking).
- Stall:
  - S1, S2, the multiplier and rr_ptr all hold.
  - No new grants; rsp_* stay stable until the handshake completes.
- Simultaneous events:
  - Response handshake and new accept in the same cycle are allowed (adv = 1): S2 takes S1, S1 takes the new op.
  - Requester behaviour: once asserted, req_valid and its operands stay stable until req_ready. Dropping valid early is illegal; the bench asserts against it.
- Fairness:
  - With all NUM_REQ requesting continuously, grants cycle 0,1,2,3,0,...
  - No requester waits more than NUM_REQ-1 grants.
- Arithmetic: the full PW-bit signed product; no saturation and no truncation.
- busy = s1_vld | rsp_valid.

Decomposition:
- Shared package mul_pkg holds:
  - W and PW constants.
  - The signed operand and product typedefs.
  - Product width function pw(W) = 2*W.
- Sub-module: mul_core_reg, a registered signed WxW->PW multiplier with clk, rst_n, en, and a 1-cycle latency.
  - It is the shared resource; the arbiter instantiates exactly one.
- Round-robin grant logic stays inline. It is small, and a separate module adds no reuse.

Test Plan:
- Reset mid-op:
  - Stimulus: accept {A=3, B=2} from req0, then assert rst_n=0 one cycle later.
  - Required: rsp_valid=0, busy=0 immediately (async); after release, no stale product appears and the first grant goes to req0.
- Single requester, exhaustive:
  - Stimulus: req2 sweeps A, B over -8..7 with rsp_ready=1.
  - Required: each rsp_p = A*B, rsp_id=2, 1 result per cycle; (-8,-8) -> +64 and (-8,7) -> -56.
- Round-robin:
  - Stimulus: all four requesters hold valid, with req_i operands A=i+1, B=-1.
  - Required: rsp sequence is id 0,1,2,3,0 with p = -1,-2,-3,-4,-1; no requester is granted twice in a row.
- Backpressure:
  - Stimulus: req1 streams {2,3},{4,5},{-3,6}; rsp_ready=0 for 3 cycles after the first result.
  - Required: rsp_p=6 is held stable; req_ready=0 during the stall; the remaining results 20 and -18 follow with no loss or duplication.
- Pointer wrap and sparse requests:
  - Stimulus: only req3 then req0 valid, then req3 again.
  - Required: grants 3, 0, 3; rr_ptr wraps 3->0->1; rsp_id matches each grant.
- Concurrent handshake:
  - Stimulus: the response handshake and a new accept occur on the same edge.
  - Required: no bubble, i.e. results arrive on consecutive cycles.
